// File: rtl/cpu_addr_decoder_bus.sv
// Address decoder / bus bridge: one CPU master to NUM_SLV register slaves.
// Each CPU access is decoded to a slave region, waits for that slave's ready
// (bounded by TIMEOUT cycles) and completes with a one-cycle cpu_ready pulse.
// Unmapped addresses and timeouts complete with cpu_err=1 and cpu_rdata=0.
module cpu_addr_decoder_bus #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int NUM_SLV = 8,
    parameter int SLV_AW  = 3,
    parameter int TIMEOUT = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cpu_sel,
    input  logic                        cpu_wr,
    input  logic [ADDR_W-1:0]           cpu_addr,
    input  logic [DATA_W-1:0]           cpu_wdata,
    output logic [DATA_W-1:0]           cpu_rdata,
    output logic                        cpu_ready,
    output logic                        cpu_err,
    output logic [NUM_SLV-1:0]          slv_sel,
    output logic                        slv_wr,
    output logic [SLV_AW-1:0]           slv_addr,
    output logic [DATA_W-1:0]           slv_wdata,
    input  logic [NUM_SLV*DATA_W-1:0]   slv_rdata,
    input  logic [NUM_SLV-1:0]          slv_ready
);

    localparam int IDX_W = ADDR_W - SLV_AW;
    // Wide enough to hold TIMEOUT-1 even when TIMEOUT is 1.
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    typedef struct packed {
        logic              wr;
        logic [SLV_AW-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } slv_req_t;

    state_t                          state;
    slv_req_t                        req_q;
    logic [NUM_SLV-1:0]              sel_q;
    logic [CNT_W-1:0]                cnt;

    logic [IDX_W-1:0]                idx;
    logic                            mapped;
    logic [NUM_SLV-1:0]              dec;
    logic [NUM_SLV-1:0]              hit;
    logic [NUM_SLV-1:0][DATA_W-1:0]  lane_rd;
    logic [DATA_W-1:0]               rd_mux;
    logic                            ready_hit;

    assign idx    = cpu_addr[ADDR_W-1:SLV_AW];
    assign mapped = 32'(idx) < 32'(NUM_SLV);

    // Per-slave lane: region decode, and ready/rdata gated by the registered
    // one-hot select so unselected slaves can never complete an access.
    for (genvar k = 0; k < NUM_SLV; k++) begin : g_lane
        assign dec[k]     = (idx == IDX_W'(k));
        assign hit[k]     = sel_q[k] & slv_ready[k];
        assign lane_rd[k] = sel_q[k] ? slv_rdata[k*DATA_W +: DATA_W] : '0;
    end

    // At most one lane is non-zero, so an OR tree is the read mux.
    always_comb begin
        rd_mux = '0;
        for (int k = 0; k < NUM_SLV; k++) begin
            rd_mux = rd_mux | lane_rd[k];
        end
    end

    assign ready_hit = |hit;

    assign slv_sel   = sel_q;
    assign slv_wr    = req_q.wr;
    assign slv_addr  = req_q.addr;
    assign slv_wdata = req_q.wdata;

    // Access FSM with all CPU- and slave-facing outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cpu_ready <= 1'b0;
            cpu_err   <= 1'b0;
            cpu_rdata <= '0;
            sel_q     <= '0;
            req_q     <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cpu_ready <= 1'b0;
                    cpu_err   <= 1'b0;
                    if (cpu_sel) begin
                        if (mapped) begin
                            state       <= ACCESS;
                            sel_q       <= dec;
                            req_q.wr    <= cpu_wr;
                            req_q.addr  <= cpu_addr[SLV_AW-1:0];
                            req_q.wdata <= cpu_wdata;
                            cnt         <= '0;
                        end else begin
                            state     <= RESP;
                            cpu_ready <= 1'b1;
                            cpu_err   <= 1'b1;
                            cpu_rdata <= '0;
                        end
                    end
                end
                ACCESS: begin
                    // Ready is checked first so it wins over a same-cycle timeout.
                    if (ready_hit) begin
                        state     <= RESP;
                        cpu_ready <= 1'b1;
                        cpu_err   <= 1'b0;
                        sel_q     <= '0;
                        if (!req_q.wr) begin
                            cpu_rdata <= rd_mux;
                        end
                    end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                        state     <= RESP;
                        cpu_ready <= 1'b1;
                        cpu_err   <= 1'b1;
                        cpu_rdata <= '0;
                        sel_q     <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RESP: begin
                    state     <= IDLE;
                    cpu_ready <= 1'b0;
                    cpu_err   <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    cpu_ready <= 1'b0;
                    cpu_err   <= 1'b0;
                    sel_q     <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_addr_decoder_bus.sv
// Bench for cpu_addr_decoder_bus: default instance with a behavioural
// register-slave model (per-slave wait states, stuck slaves, forced data),
// plus a narrow-region instance for the NUM_SLV=4/SLV_AW=2/DATA_W=16 sweep.
module tb_cpu_addr_decoder_bus;

    logic        clk;
    logic        rst;
    logic        cpu_sel;
    logic        cpu_wr;
    logic [7:0]  cpu_addr;
    logic [7:0]  cpu_wdata;
    logic [7:0]  cpu_rdata;
    logic        cpu_ready;
    logic        cpu_err;
    logic [7:0]  slv_sel;
    logic        slv_wr;
    logic [2:0]  slv_addr;
    logic [7:0]  slv_wdata;
    logic [63:0] slv_rdata;
    logic [7:0]  slv_ready;

    logic        b_sel;
    logic        b_wr;
    logic [7:0]  b_addr;
    logic [15:0] b_wdata;
    logic [15:0] b_rdata;
    logic        b_ready;
    logic        b_err;
    logic [3:0]  b_slv_sel;
    logic        b_slv_wr;
    logic [1:0]  b_slv_addr;
    logic [15:0] b_slv_wdata;
    logic [63:0] b_slv_rdata;
    logic [3:0]  b_slv_ready;

    int total = 0;
    int bad   = 0;

    // slave model state
    bit [7:0] mem [64];
    int       wait_req [8];
    bit       never [8];
    bit       ovr_en [8];
    bit [7:0] ovr [8];
    bit [7:0] extra_rdy;
    int       wcnt;

    cpu_addr_decoder_bus dut (
        .clk(clk), .rst(rst),
        .cpu_sel(cpu_sel), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .cpu_err(cpu_err),
        .slv_sel(slv_sel), .slv_wr(slv_wr), .slv_addr(slv_addr), .slv_wdata(slv_wdata),
        .slv_rdata(slv_rdata), .slv_ready(slv_ready)
    );

    cpu_addr_decoder_bus #(.ADDR_W(8), .DATA_W(16), .NUM_SLV(4), .SLV_AW(2), .TIMEOUT(16)) dut_b (
        .clk(clk), .rst(rst),
        .cpu_sel(b_sel), .cpu_wr(b_wr), .cpu_addr(b_addr), .cpu_wdata(b_wdata),
        .cpu_rdata(b_rdata), .cpu_ready(b_ready), .cpu_err(b_err),
        .slv_sel(b_slv_sel), .slv_wr(b_slv_wr), .slv_addr(b_slv_addr), .slv_wdata(b_slv_wdata),
        .slv_rdata(b_slv_rdata), .slv_ready(b_slv_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign b_slv_ready = b_slv_sel;
    assign b_slv_rdata = {16'h3333, 16'h2222, 16'h1111, 16'h0000};

    // cycles the current access has been selected (0 at the first ACCESS edge)
    always @(posedge clk) wcnt <= (slv_sel != 8'h00) ? wcnt + 1 : 0;

    always_comb begin
        for (int k = 0; k < 8; k++) begin
            slv_ready[k] = (slv_sel[k] && !never[k] && (wcnt >= wait_req[k])) || extra_rdy[k];
            slv_rdata[k*8 +: 8] = ovr_en[k] ? ovr[k] : mem[k*8 + int'(slv_addr)];
        end
    end

    always @(posedge clk) begin
        for (int k = 0; k < 8; k++) begin
            if (slv_sel[k] && slv_ready[k] && slv_wr) mem[k*8 + int'(slv_addr)] <= slv_wdata;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // One CPU access on the default instance; latency counted in cycles after edge N.
    task automatic run(input bit wr, input logic [7:0] addr, input logic [7:0] wdata,
                       input int exp_lat, input bit exp_err, input logic [7:0] exp_rd,
                       input logic [7:0] exp_sel, input string nm);
        int lat;
        bit sel_ok;
        bit req_ok;
        @(negedge clk);
        cpu_sel = 1'b1; cpu_wr = wr; cpu_addr = addr; cpu_wdata = wdata;
        @(posedge clk); #1;
        cpu_sel = 1'b0;
        lat = 1;
        sel_ok = 1'b1;
        req_ok = (slv_wr == wr) && (slv_addr == addr[2:0]) && (slv_wdata == wdata);
        while (!cpu_ready && lat < 40) begin
            if (slv_sel !== exp_sel) sel_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        if (slv_sel !== 8'h00) sel_ok = 1'b0;
        chk({nm, ".lat"}, lat, exp_lat);
        chk({nm, ".err"}, cpu_err, exp_err);
        chk({nm, ".rdata"}, cpu_rdata, exp_rd);
        chk({nm, ".sel"}, sel_ok, 1);
        if (exp_sel != 8'h00) chk({nm, ".req"}, req_ok, 1);
        @(posedge clk); #1;
        chk({nm, ".drop"}, {cpu_ready, cpu_err}, 2'b00);
    endtask

    typedef struct {
        bit       wr;
        bit [7:0] addr;
        bit [7:0] wdata;
        int       lat;
        bit       err;
        bit [7:0] rd;
        bit [7:0] sel;
    } vec_t;

    vec_t     tbl [22];
    bit [7:0] last_rd;
    bit [7:0] d;
    bit [7:0] d0;
    bit       seen;

    initial begin
        rst = 1'b1; cpu_sel = 1'b0; cpu_wr = 1'b0; cpu_addr = 8'h00; cpu_wdata = 8'h00;
        b_sel = 1'b0; b_wr = 1'b0; b_addr = 8'h00; b_wdata = 16'h0000;
        extra_rdy = 8'h00;

        // write/read-back pairs over addr 0..9, then two unmapped accesses
        last_rd = 8'h00;
        for (int a = 0; a < 10; a++) begin
            d = 8'($urandom_range(0, 255));
            if (a == 0) d0 = d;
            tbl[2*a]   = '{1'b1, 8'(a), d,     2, 1'b0, last_rd, 8'(1 << (a >> 3))};
            tbl[2*a+1] = '{1'b0, 8'(a), 8'h00, 2, 1'b0, d,       8'(1 << (a >> 3))};
            last_rd = d;
        end
        tbl[20] = '{1'b1, 8'h48, 8'h5C, 1, 1'b1, 8'h00, 8'h00};
        tbl[21] = '{1'b0, 8'h40, 8'h00, 1, 1'b1, 8'h00, 8'h00};

        repeat (2) @(posedge clk);
        #1;
        chk("reset.ready", cpu_ready, 0);
        chk("reset.err", cpu_err, 0);
        chk("reset.rdata", cpu_rdata, 0);
        chk("reset.sel", slv_sel, 0);
        chk("reset.slv", {slv_wr, slv_addr, slv_wdata}, 0);
        chk("reset.b", {b_ready, b_err, b_slv_sel}, 0);
        @(negedge clk) rst = 1'b0;

        for (int i = 0; i < 22; i++) begin
            run(tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].lat, tbl[i].err,
                tbl[i].rd, tbl[i].sel, $sformatf("vec%0d", i));
        end

        // slave 2: three wait cycles, forced read data
        wait_req[2] = 3; ovr_en[2] = 1'b1; ovr[2] = 8'hA5;
        run(1'b0, 8'h12, 8'h00, 5, 1'b0, 8'hA5, 8'h04, "wait3");
        wait_req[2] = 0; ovr_en[2] = 1'b0;

        // slave 5 stuck; slave 4 ready held high throughout must be ignored
        never[5] = 1'b1; extra_rdy[4] = 1'b1;
        run(1'b0, 8'h28, 8'h00, 17, 1'b1, 8'h00, 8'h20, "tmo");
        never[5] = 1'b0; extra_rdy[4] = 1'b0;

        // reset during a write ACCESS to 0x1F
        wait_req[3] = 5;
        @(negedge clk);
        cpu_sel = 1'b1; cpu_wr = 1'b1; cpu_addr = 8'h1F; cpu_wdata = 8'h77;
        @(posedge clk); #1;
        cpu_sel = 1'b0;
        chk("rst.inacc", slv_sel, 8'h08);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        chk("rst.sel", slv_sel, 0);
        chk("rst.ready", cpu_ready, 0);
        @(negedge clk) rst = 1'b0;
        seen = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            if (cpu_ready || slv_sel != 8'h00) seen = 1'b1;
        end
        chk("rst.nopulse", seen, 0);
        chk("rst.nowrite", mem[31], 0);
        wait_req[3] = 0;
        run(1'b0, 8'h00, 8'h00, 2, 1'b0, d0, 8'h01, "rst.rd0");

        // slave 3 ready on the same edge the counter reaches TIMEOUT-1
        wait_req[3] = 15; ovr_en[3] = 1'b1; ovr[3] = 8'h3C;
        run(1'b0, 8'h18, 8'h00, 17, 1'b0, 8'h3C, 8'h08, "edge");
        wait_req[3] = 0; ovr_en[3] = 1'b0;

        // narrow instance: 0x10 is idx 4, unmapped with 4 slaves
        @(negedge clk);
        b_sel = 1'b1; b_wr = 1'b0; b_addr = 8'h10;
        @(posedge clk); #1;
        b_sel = 1'b0;
        chk("b.unmap", {b_ready, b_err, b_slv_sel}, 6'b11_0000);
        chk("b.unmap.rdata", b_rdata, 0);
        @(posedge clk); #1;
        chk("b.unmap.drop", b_ready, 0);
        // 0x0D is slave 3, offset 1
        @(negedge clk);
        b_sel = 1'b1; b_wr = 1'b0; b_addr = 8'h0D; b_wdata = 16'h5A5A;
        @(posedge clk); #1;
        b_sel = 1'b0;
        chk("b.acc", {b_ready, b_slv_sel, b_slv_wr, b_slv_addr}, {1'b0, 4'b1000, 1'b0, 2'd1});
        chk("b.acc.wdata", b_slv_wdata, 16'h5A5A);
        @(posedge clk); #1;
        chk("b.resp", {b_ready, b_err, b_slv_sel}, 6'b10_0000);
        chk("b.resp.rdata", b_rdata, 16'h3333);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cpu_addr_decoder_bus.md
Name: cpu_addr_decoder_bus

Overview:
Parametrised address decoder and bus bridge between the single-master CPU bus model and NUM_SLV register-slave ports. It decodes each CPU access to one slave region and tolerates slave wait states. It flags unmapped addresses and slave timeouts through an error response. It generalises the fixed 8-register decoder to configurable width, region size and slave count, and adds a ready/error handshake.

Parameters:
ADDR_W, 8, CPU address width in bits
DATA_W, 8, data width in bits
NUM_SLV, 8, number of slave ports; legal range 1 to 2**(ADDR_W-SLV_AW)
SLV_AW, 3, word-address width inside one slave region (region = 2**SLV_AW words)
TIMEOUT, 16, maximum ACCESS cycles without slv_ready before error; minimum 1

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  synchronous active-high reset
cpu_sel  in  1  CPU request strobe; sampled only in IDLE
cpu_wr  in  1  1 = write, 0 = read; sampled with cpu_sel
cpu_addr  in  ADDR_W  CPU word address
cpu_wdata  in  DATA_W  write data
cpu_rdata  out  DATA_W  read data; valid while cpu_ready=1
cpu_ready  out  1  one-cycle completion pulse
cpu_err  out  1  error status; valid while cpu_ready=1
slv_sel  out  NUM_SLV  one-hot slave select
slv_wr  out  1  write qualifier to the slaves
slv_addr  out  SLV_AW  offset within the region (cpu_addr[SLV_AW-1:0])
slv_wdata  out  DATA_W  write data to the slaves
slv_rdata  in  NUM_SLV*DATA_W  flattened read data; slave k occupies bits [k*DATA_W +: DATA_W]
slv_ready  in  NUM_SLV  per-slave completion; only the selected bit is honoured

Behaviour:
- Reset (synchronous, rst=1 at a clock edge): state=IDLE; cpu_ready=0; cpu_err=0; cpu_rdata=0; slv_sel=0; slv_wr=0; slv_addr=0; slv_wdata=0; timeout counter=0. Reset aborts any access in flight. The aborted access gets no cpu_ready pulse.
- Decode: idx = cpu_addr[ADDR_W-1:SLV_AW]. The address is mapped iff idx < NUM_SLV.
- All outputs are registered. FSM states: IDLE, ACCESS, RESP.
- IDLE: cpu_sel=1 at edge N latches wr, addr, wdata and idx.
  - Mapped: enter ACCESS. From cycle N+1, slv_sel[idx]=1 and slv_wr/slv_addr/slv_wdata are driven. Counter cleared.
  - Unmapped: enter RESP. From cycle N+1, cpu_ready=1, cpu_err=1, cpu_rdata=0. No slv_sel is asserted.
- ACCESS: slv_sel, slv_wr, slv_addr and slv_wdata are held stable every cycle.
  - slv_ready[idx]=1 at an edge: a read captures the slv_rdata slice of idx into cpu_rdata. Next state RESP with cpu_err=0. slv_sel drops to 0 in the same cycle.
  - Otherwise the counter increments. If the counter reaches TIMEOUT-1 with ready still low, next state is RESP with cpu_err=1 and cpu_rdata=0. slv_sel drops.
  - slv_ready and timeout at the same edge: ready wins (no error).
  - slv_ready bits of unselected slaves are ignored.
- RESP: lasts exactly one cycle with cpu_ready=1. Next state is always IDLE, and cpu_ready/cpu_err return to 0.
  - cpu_rdata holds its value until the next read completes or reset.
  - Write completions leave cpu_rdata unchanged.
- cpu_sel is ignored in ACCESS and RESP; no queuing. A master holding cpu_sel high through RESP starts a new access at the first IDLE edge. Minimum back-to-back spacing is 3 cycles for mapped accesses.
- Latency: zero-wait slave gives cpu_ready 2 cycles after the cpu_sel edge (N+2). Each slave wait cycle adds 1. Unmapped accesses take 1 cycle. Timeout gives cpu_ready at N+1+TIMEOUT.
- At most one slv_sel bit is high at any time; the cycle after reset has all bits low.

Test Plan:
- Zero-wait slaves, defaults: for addr 0..9, write $random data, then read back the same address. Each response: cpu_ready at N+2, cpu_err=0, read data == written data. Addr 9 must select slave 1 with slv_addr=1.
- Read addr 0x40 (idx 8 ≥ NUM_SLV): cpu_ready=1 and cpu_err=1 at N+1, cpu_rdata=0, slv_sel stays 0 throughout.
- Slave 2 holds slv_ready low for 3 cycles, then returns 0xA5 on a read of addr 0x12: cpu_ready at N+5, cpu_rdata=0xA5, cpu_err=0, slv_sel=8'b0000_0100 stable across all ACCESS cycles.
- Slave 5 never readies, TIMEOUT=16: cpu_ready at N+17, cpu_err=1, cpu_rdata=0; slv_ready pulsed on slave 4 during the wait is ignored.
- Assert rst during ACCESS of a write to addr 0x1F: the next cycle shows slv_sel=0 and cpu_ready=0 with no response pulse. A following read to addr 0x00 completes normally.
- Slave 3 ready exactly at the cycle the counter hits TIMEOUT-1: the response has cpu_err=0 with valid data. A parameter sweep NUM_SLV=4, SLV_AW=2, DATA_W=16 shows addr 0x10 returns an error.
